// File: rtl/datapath_ctrl_pkg.sv
// Shared definitions for the datapath control sequencer:
// opcodes, ALU codes, instruction fields, FSM states, decode bundle.
package datapath_ctrl_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_AND   = 4'd3;
  localparam logic [3:0] OP_OR    = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_MOV   = 4'd6;
  localparam logic [3:0] OP_LOAD  = 4'd7;
  localparam logic [3:0] OP_STORE = 4'd8;

  localparam logic [1:0] ALU_AND = 2'd0;
  localparam logic [1:0] ALU_OR  = 2'd1;
  localparam logic [1:0] ALU_XOR = 2'd2;
  localparam logic [1:0] ALU_ADD = 2'd3;

  localparam int OP_LSB = 6;
  localparam int RD_LSB = 4;
  localparam int RA_LSB = 2;
  localparam int RB_LSB = 0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_A_SET,
    S_A_STB,
    S_A_HLD,
    S_D_SET,
    S_D_STB,
    S_M_STB,
    S_M_HLD,
    S_W_SET,
    S_W_STB,
    S_W_HLD,
    S_NOP
  } state_e;

  typedef enum logic [2:0] {
    C_ALU,
    C_LOAD,
    C_STORE,
    C_NOP,
    C_ILL
  } op_class_e;

  typedef struct packed {
    op_class_e  cls;
    logic [1:0] func;
    logic       comp_b;
    logic       ci;
    logic [1:0] a_sel;
    logic [1:0] b_sel;
    logic       sets_flags;
  } dec_t;

  function automatic logic [3:0] f_op(input logic [9:0] i);
    return i[OP_LSB +: 4];
  endfunction

  function automatic logic [1:0] f_rd(input logic [9:0] i);
    return i[RD_LSB +: 2];
  endfunction

  function automatic logic [1:0] f_ra(input logic [9:0] i);
    return i[RA_LSB +: 2];
  endfunction

  function automatic logic [1:0] f_rb(input logic [9:0] i);
    return i[RB_LSB +: 2];
  endfunction

endpackage

// File: rtl/datapath_ctrl_decode.sv
// Combinational opcode decoder: instruction class plus the
// ALU select set used while the result is written back.
module ctrl_decode
  import datapath_ctrl_pkg::*;
(
  input  logic [9:0] instr_i,
  output dec_t       dec_o
);

  logic [3:0] op;
  logic [1:0] ra;
  logic [1:0] rb;

  assign op = f_op(instr_i);
  assign ra = f_ra(instr_i);
  assign rb = f_rb(instr_i);

  // Address, MOV and STORE data all pass through the ALU as a|a
  always_comb begin
    dec_o.cls        = C_ILL;
    dec_o.func       = ALU_OR;
    dec_o.comp_b     = 1'b0;
    dec_o.ci         = 1'b0;
    dec_o.a_sel      = ra;
    dec_o.b_sel      = ra;
    dec_o.sets_flags = 1'b0;
    unique case (1'b1)
      (op == OP_NOP): dec_o.cls = C_NOP;
      (op == OP_ADD): begin
        dec_o.cls        = C_ALU;
        dec_o.func       = ALU_ADD;
        dec_o.b_sel      = rb;
        dec_o.sets_flags = 1'b1;
      end
      (op == OP_SUB): begin
        dec_o.cls        = C_ALU;
        dec_o.func       = ALU_ADD;
        dec_o.comp_b     = 1'b1;
        dec_o.ci         = 1'b1;
        dec_o.b_sel      = rb;
        dec_o.sets_flags = 1'b1;
      end
      (op == OP_AND): begin
        dec_o.cls   = C_ALU;
        dec_o.func  = ALU_AND;
        dec_o.b_sel = rb;
      end
      (op == OP_OR): begin
        dec_o.cls   = C_ALU;
        dec_o.func  = ALU_OR;
        dec_o.b_sel = rb;
      end
      (op == OP_XOR): begin
        dec_o.cls   = C_ALU;
        dec_o.func  = ALU_XOR;
        dec_o.b_sel = rb;
      end
      (op == OP_MOV):   dec_o.cls = C_ALU;
      (op == OP_LOAD):  dec_o.cls = C_LOAD;
      (op == OP_STORE): dec_o.cls = C_STORE;
      default: ;
    endcase
  end

endmodule

// File: rtl/datapath_ctrl.sv
// Instruction sequencer for the 8-bit register/ALU/MAR/MBR datapath:
// expands one instruction into timed strobes and held selects.
module datapath_ctrl
  import datapath_ctrl_pkg::*;
#(
  parameter int unsigned HOLD = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [9:0] instr,
  output logic       done,
  output logic       err_illegal,
  output logic       flag_so,
  output logic       flag_uo,
  input  logic       alu_so,
  input  logic       alu_uo,
  output logic [1:0] reg_addr_we,
  output logic       reg_we,
  output logic       mar_we,
  output logic       mbr_out_we,
  output logic       mbr_in_we,
  output logic       mem_we,
  output logic       mbr_alu,
  output logic [1:0] alu_func,
  output logic       alu_comp_b,
  output logic       alu_ci,
  output logic [1:0] alu_reg_a,
  output logic [1:0] alu_reg_b
);

  localparam logic [2:0] HOLD_M1 = 3'(HOLD - 1);
  localparam logic       LAST1   = (HOLD_M1 == 3'd0);

  state_e     state_q;
  logic [2:0] cnt_q;
  logic [9:0] instr_q;
  op_class_e  cls_q;
  logic       flg_q;
  logic       done_q;
  logic       err_q;
  logic       so_q;
  logic       uo_q;
  logic       reg_we_q;
  logic       mar_we_q;
  logic       mbo_we_q;
  logic       mbi_we_q;
  logic       mem_we_q;
  logic [1:0] rad_q;
  logic       mbr_alu_q;
  logic [1:0] func_q;
  logic       comp_q;
  logic       ci_q;
  logic [1:0] ra_q;
  logic [1:0] rb_q;

  logic [9:0] dec_in;
  dec_t       dec;

  assign dec_in = (state_q == S_IDLE) ? instr : instr_q;

  ctrl_decode u_dec (
    .instr_i (dec_in),
    .dec_o   (dec)
  );

  // Sequencer: state, hold counter and every registered output
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 3'd0;
      instr_q   <= 10'd0;
      cls_q     <= C_NOP;
      flg_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      so_q      <= 1'b0;
      uo_q      <= 1'b0;
      reg_we_q  <= 1'b0;
      mar_we_q  <= 1'b0;
      mbo_we_q  <= 1'b0;
      mbi_we_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      rad_q     <= 2'd0;
      mbr_alu_q <= 1'b0;
      func_q    <= 2'd0;
      comp_q    <= 1'b0;
      ci_q      <= 1'b0;
      ra_q      <= 2'd0;
      rb_q      <= 2'd0;
    end else begin
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      reg_we_q <= 1'b0;
      mar_we_q <= 1'b0;
      mbo_we_q <= 1'b0;
      mbi_we_q <= 1'b0;
      mem_we_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (instr_valid) begin
            instr_q <= instr;
            cls_q   <= dec.cls;
            flg_q   <= dec.sets_flags;
            unique case (dec.cls)
              C_ALU: begin
                state_q   <= S_W_SET;
                mbr_alu_q <= 1'b0;
                func_q    <= dec.func;
                comp_q    <= dec.comp_b;
                ci_q      <= dec.ci;
                ra_q      <= dec.a_sel;
                rb_q      <= dec.b_sel;
                rad_q     <= f_rd(instr);
              end
              C_LOAD, C_STORE: begin
                state_q   <= S_A_SET;
                mbr_alu_q <= 1'b0;
                func_q    <= dec.func;
                comp_q    <= dec.comp_b;
                ci_q      <= dec.ci;
                ra_q      <= dec.a_sel;
                rb_q      <= dec.b_sel;
              end
              default: begin
                state_q <= S_NOP;
                done_q  <= 1'b1;
                err_q   <= (dec.cls == C_ILL);
              end
            endcase
          end
        end
        S_A_SET: begin
          state_q  <= S_A_STB;
          mar_we_q <= 1'b1;
        end
        S_A_STB: begin
          state_q <= S_A_HLD;
          cnt_q   <= HOLD_M1;
        end
        S_A_HLD: begin
          if (cnt_q == 3'd0) begin
            state_q <= S_D_SET;
            if (cls_q == C_STORE) begin
              ra_q <= f_rb(instr_q);
              rb_q <= f_rb(instr_q);
            end
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        S_D_SET: begin
          state_q <= S_D_STB;
          if (cls_q == C_STORE) mbo_we_q <= 1'b1;
          else                  mbi_we_q <= 1'b1;
        end
        S_D_STB: begin
          if (cls_q == C_STORE) begin
            state_q  <= S_M_STB;
            mem_we_q <= 1'b1;
          end else begin
            state_q   <= S_W_SET;
            mbr_alu_q <= 1'b1;
            rad_q     <= f_rd(instr_q);
          end
        end
        S_M_STB: begin
          state_q <= S_M_HLD;
          cnt_q   <= HOLD_M1;
          done_q  <= LAST1;
        end
        S_W_SET: begin
          state_q  <= S_W_STB;
          reg_we_q <= 1'b1;
        end
        S_W_STB: begin
          state_q <= S_W_HLD;
          cnt_q   <= HOLD_M1;
          done_q  <= LAST1;
          if (flg_q) begin
            so_q <= alu_so;
            uo_q <= alu_uo;
          end
        end
        S_M_HLD, S_W_HLD: begin
          if (cnt_q == 3'd0) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q  <= cnt_q - 3'd1;
            done_q <= (cnt_q == 3'd1);
          end
        end
        S_NOP:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign instr_ready = (state_q == S_IDLE);
  assign done        = done_q;
  assign err_illegal = err_q;
  assign flag_so     = so_q;
  assign flag_uo     = uo_q;
  assign reg_addr_we = rad_q;
  assign reg_we      = reg_we_q;
  assign mar_we      = mar_we_q;
  assign mbr_out_we  = mbo_we_q;
  assign mbr_in_we   = mbi_we_q;
  assign mem_we      = mem_we_q;
  assign mbr_alu     = mbr_alu_q;
  assign alu_func    = func_q;
  assign alu_comp_b  = comp_q;
  assign alu_ci      = ci_q;
  assign alu_reg_a   = ra_q;
  assign alu_reg_b   = rb_q;

endmodule
